pipe_mul: RTL and testbench
===========================

// Module: pipe_mul
// PURPOSE
// - Parametrised pipelined multiplier, successor to the fixed 4x4 retiming-test multiplier.
// - Multiplies a by b. Widths, input and output pipeline depth, and signedness are set by parameters.
// - Adds a valid/ready handshake with backpressure and an in-flight counter.
// - Sits between bounding registers in retime/fmax experiments; also usable as a datapath block.
// PARAMETERS
// - A_WIDTH     4  width of operand a
// - B_WIDTH     4  width of operand b
// - IN_STAGES   1  register stages before the multiply (0..8)
// - OUT_STAGES  1  register stages after the multiply (0..8)
// - SIGNED      0  0 = unsigned product; 1 = two's-complement product
// - Derived: D = IN_STAGES+OUT_STAGES; Q_WIDTH = A_WIDTH+B_WIDTH; CW = $clog2(D+1), minimum 1
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous active-low reset
// - in_valid   in   1        a/b valid this cycle
// - in_ready   out  1        block accepts a/b this cycle
// - a          in   A_WIDTH  operand a
// - b          in   B_WIDTH  operand b
// - out_valid  out  1        q valid
// - out_ready  in   1        downstream accepts q
// - q          out  Q_WIDTH  full-width product, never truncated
// - inflight   out  CW       number of valid entries currently held in stages
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
// - Reset value of every output:
//   - all stage valid bits, all stage data regs, and inflight clear to 0
//   - so out_valid=0, q=0, in_ready=1
// - Reset asserted mid-operation discards all in-flight entries immediately.
// - Transfers: input transfer = in_valid&&in_ready; output transfer = out_valid&&out_ready.
// - Pipeline: each stage holds one {valid,data} entry.
//   - Input stages carry {a,b}.
//   - The multiply sits between stage IN_STAGES-1 and stage IN_STAGES.
//   - Output stages carry the product.
// - Latency: D cycles from input transfer to out_valid when there is no stall.
// - D==0: purely combinational.
//   - q = a*b, out_valid = in_valid, in_ready = out_ready, inflight = 0.
// - Stall (default, global enable):
//   - adv = !out_valid || out_ready.
//   - All stages shift only when adv=1; in_ready = adv.
//   - While adv=0, q and out_valid are held stable; no entry is lost or duplicated.
// - Bubbles: invalid entries shift like valid ones. Their data is don't-care, but it still shifts.
// - Ordering is strictly FIFO.
// - Arithmetic:
//   - SIGNED=0: zero-extend both operands to Q_WIDTH.
//   - SIGNED=1: sign-extend both operands to Q_WIDTH.
//   - The product is taken mod 2^Q_WIDTH, which is exact for both modes.
// - inflight:
//   - +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
//   - Range 0..D; never wraps.
// CONFIGURATION
// - Optional macro: PIPE_MUL_BUBBLE_COLLAPSE_EN.
// - Undefined: global-enable stall as described under BEHAVIOUR.
// - Defined: each stage has its own ready.
//   - ready_k = !valid_k || ready_{k+1}, with ready_D = out_ready; in_ready = ready_0.
//   - Stage k loads when ready_k=1.
//   - Empty stages fill during a stall, so the pipeline absorbs up to D entries before in_ready drops.
//   - Latency, ordering, arithmetic and reset are unchanged.
//   - The ready chain is combinational across stages.
// TESTING
// - Unsigned (A=B=4, IN=1, OUT=1, SIGNED=0):
//   - a=15, b=15, in_valid pulse, out_ready=1 -> out_valid=1 exactly 2 cycles later, q=0xE1.
//   - Back-to-back pairs (3,5), (0,9), (15,1) -> q = 0x0F, 0x00, 0x0F on consecutive cycles.
// - Signed (SIGNED=1):
//   - a=4'b1000, b=4'b1000 -> q=0x40.
//   - a=4'b1000, b=4'b0111 -> q=0xC8.
//   - a=4'b1111, b=4'b0001 -> q=0xFF.
// - Backpressure, default build:
//   - Stream 4 products with out_ready low for 3 cycles mid-stream.
//   - q is held stable while stalled, in_ready=0 while out_valid && !out_ready, all 4 results arrive in order.
//   - inflight never exceeds 2.
// - Bubble collapse (PIPE_MUL_BUBBLE_COLLAPSE_EN, IN=2, OUT=2):
//   - Send one entry, then stall out_ready.
//   - in_ready stays 1 until inflight=4, then drops to 0.
// - Reset mid-operation:
//   - Drop rst_n with 2 entries in flight -> out_valid=0, q=0, inflight=0 immediately.
//   - No stale output appears after release.
// - Combinational (IN=0, OUT=0):
//   - a=7, b=9 -> q=0x3F in the same cycle.
//   - in_ready tracks out_ready.

Source files
------------

// File: rtl/pipe_mul.sv
// pipe_mul: parametrised pipelined multiplier with valid/ready handshake.
//
// q = a * b, full Q_WIDTH = A_WIDTH + B_WIDTH product, unsigned or two's
// complement (SIGNED). IN_STAGES register stages carry {a,b} ahead of the
// multiplier; OUT_STAGES stages carry the product after it. With zero total
// stages the block is purely combinational.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b valid this cycle
//   in_ready   out  block accepts a/b this cycle
//   a, b       in   operands
//   out_valid  out  q valid
//   out_ready  in   downstream accepts q
//   q          out  full-width product
//   inflight   out  number of valid entries held in the stages
//
// Build option: define PIPE_MUL_BUBBLE_COLLAPSE_EN for per-stage ready so
// empty stages keep filling while the output is stalled. Undefined, every
// stage advances on one global enable.
module pipe_mul #(
    parameter  int A_WIDTH    = 4,
    parameter  int B_WIDTH    = 4,
    parameter  int IN_STAGES  = 1,
    parameter  int OUT_STAGES = 1,
    parameter  int SIGNED     = 0,
    localparam int D          = IN_STAGES + OUT_STAGES,
    localparam int Q_WIDTH    = A_WIDTH + B_WIDTH,
    localparam int CW         = (D == 0) ? 1 : $clog2(D + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] q,
    output logic [CW-1:0]      inflight
);

    // Operand pair {a,b} is exactly Q_WIDTH bits, so input and output stages
    // share one register width. Extending both operands to Q_WIDTH and keeping
    // the low Q_WIDTH bits gives the exact product in either signedness.
    function automatic logic [Q_WIDTH-1:0] mul_op(input logic [Q_WIDTH-1:0] ab);
        logic [Q_WIDTH-1:0] ax;
        logic [Q_WIDTH-1:0] bx;
        if (SIGNED != 0) begin
            ax = {{B_WIDTH{ab[Q_WIDTH-1]}}, ab[Q_WIDTH-1 -: A_WIDTH]};
            bx = {{A_WIDTH{ab[B_WIDTH-1]}}, ab[B_WIDTH-1:0]};
        end else begin
            ax = {{B_WIDTH{1'b0}}, ab[Q_WIDTH-1 -: A_WIDTH]};
            bx = {{A_WIDTH{1'b0}}, ab[B_WIDTH-1:0]};
        end
        return ax * bx;
    endfunction

    if (D == 0) begin : g_comb
        assign q         = mul_op({a, b});
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign inflight  = '0;
    end else begin : g_pipe
        logic [D-1:0]       valid_q, valid_d;
        logic [Q_WIDTH-1:0] data_q [D];
        logic [Q_WIDTH-1:0] data_d [D];
        logic [D-1:0]       ready;
        logic [CW-1:0]      inflight_q, inflight_d;
        logic               in_xfer, out_xfer;

        always_comb begin
            ready = '0;
`ifdef PIPE_MUL_BUBBLE_COLLAPSE_EN
            // ready_k = !valid_k || ready_{k+1}; folded through a running
            // variable so no vector bit feeds another bit of itself.
            begin
                logic acc;
                acc = out_ready;
                for (int unsigned k = D; k > 0; k--) begin
                    acc          = acc || !valid_q[k-1];
                    ready[k-1]   = acc;
                end
            end
`else
            ready = {D{!valid_q[D-1] || out_ready}};
`endif
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            for (int unsigned k = 0; k < D; k++) begin
                if (ready[k]) begin
                    if (k == 0) begin
                        valid_d[0] = in_valid;
                        data_d[0]  = (IN_STAGES == 0) ? mul_op({a, b}) : {a, b};
                    end else begin
                        valid_d[k] = valid_q[k-1];
                        data_d[k]  = (k == unsigned'(IN_STAGES)) ? mul_op(data_q[k-1])
                                                                 : data_q[k-1];
                    end
                end
            end
        end

        always_comb begin
            in_xfer    = in_valid && ready[0];
            out_xfer   = valid_q[D-1] && out_ready;
            inflight_d = inflight_q;
            case ({in_xfer, out_xfer})
                2'b10:   inflight_d = inflight_q + CW'(1);
                2'b01:   inflight_d = inflight_q - CW'(1);
                default: inflight_d = inflight_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q    <= '0;
                inflight_q <= '0;
                for (int unsigned k = 0; k < D; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                valid_q    <= valid_d;
                inflight_q <= inflight_d;
                data_q     <= data_d;
            end
        end

        assign out_valid = valid_q[D-1];
        assign q         = (OUT_STAGES == 0) ? mul_op(data_q[D-1]) : data_q[D-1];
        assign in_ready  = ready[0];
        assign inflight  = inflight_q;
    end

endmodule

// File: tb/tb_pipe_mul.sv
// Directed self-checking bench for pipe_mul: unsigned, signed, combinational
// and a 2+2-stage instance whose stall behaviour depends on
// PIPE_MUL_BUBBLE_COLLAPSE_EN.
module tb_pipe_mul;

    logic clk;
    logic rst_n;

    // Unsigned 1+1
    logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready;
    logic [3:0] u_a, u_b;
    logic [7:0] u_q;
    logic [1:0] u_inflight;
    // Signed 1+1
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0] s_a, s_b;
    logic [7:0] s_q;
    logic [1:0] s_inflight;
    // Combinational 0+0
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [3:0] c_a, c_b;
    logic [7:0] c_q;
    logic [0:0] c_inflight;
    // 2+2
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [3:0] d_a, d_b;
    logic [7:0] d_q;
    logic [2:0] d_inflight;

    pipe_mul #(.A_WIDTH(4), .B_WIDTH(4), .IN_STAGES(1), .OUT_STAGES(1), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .a(u_a), .b(u_b), .out_valid(u_out_valid), .out_ready(u_out_ready),
        .q(u_q), .inflight(u_inflight));

    pipe_mul #(.A_WIDTH(4), .B_WIDTH(4), .IN_STAGES(1), .OUT_STAGES(1), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .q(s_q), .inflight(s_inflight));

    pipe_mul #(.A_WIDTH(4), .B_WIDTH(4), .IN_STAGES(0), .OUT_STAGES(0), .SIGNED(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .a(c_a), .b(c_b), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .q(c_q), .inflight(c_inflight));

    pipe_mul #(.A_WIDTH(4), .B_WIDTH(4), .IN_STAGES(2), .OUT_STAGES(2), .SIGNED(0)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .q(d_q), .inflight(d_inflight));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed vectors
    logic [3:0] b2b_a   [3] = '{4'd3, 4'd0, 4'd15};
    logic [3:0] b2b_b   [3] = '{4'd5, 4'd9, 4'd1};
    logic [7:0] b2b_exp [3] = '{8'h0F, 8'h00, 8'h0F};
    logic [3:0] sg_a    [3] = '{4'b1000, 4'b1000, 4'b1111};
    logic [3:0] sg_b    [3] = '{4'b1000, 4'b0111, 4'b0001};
    logic [7:0] sg_exp  [3] = '{8'h40, 8'hC8, 8'hFF};
    logic [3:0] bp_a    [4] = '{4'd2, 4'd4, 4'd7, 4'd9};
    logic [3:0] bp_b    [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
    logic [7:0] bp_exp  [4] = '{8'h06, 8'h14, 8'h31, 8'h51};
    logic [7:0] bc_exp  [4] = '{8'h09, 8'h02, 8'h04, 8'h06};
`ifdef PIPE_MUL_BUBBLE_COLLAPSE_EN
    logic       bc_rdy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] bc_cnt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    int         bc_n        = 4;
`else
    logic       bc_rdy  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] bc_cnt  [4] = '{3'd1, 3'd1, 3'd1, 3'd1};
    int         bc_n        = 1;
`endif

    initial begin
        int   idx, oidx, n;
        logic held_v, in_x, out_x;
        logic [7:0] held_q;

        rst_n = 1'b0;
        {u_in_valid, u_out_ready, u_a, u_b} = '0;
        {s_in_valid, s_out_ready, s_a, s_b} = '0;
        {c_in_valid, c_out_ready, c_a, c_b} = '0;
        {d_in_valid, d_out_ready, d_a, d_b} = '0;
        #2;
        chk("rst_out_valid", u_out_valid, 0);
        chk("rst_q",         u_q,         0);
        chk("rst_in_ready",  u_in_ready,  1);
        chk("rst_inflight",  u_inflight,  0);
        #10 rst_n = 1'b1;
        tick;

        // Single 15*15 with latency 2
        u_out_ready = 1'b1;
        u_in_valid = 1'b1; u_a = 4'd15; u_b = 4'd15;
        tick;
        u_in_valid = 1'b0;
        chk("lat_early_valid", u_out_valid, 0);
        tick;
        chk("lat_valid", u_out_valid, 1);
        chk("lat_q",     u_q,         8'hE1);
        tick;
        chk("lat_gone", u_out_valid, 0);

        // Back-to-back unsigned
        for (int i = 0; i < 4; i++) begin
            u_in_valid = (i < 3);
            if (i < 3) begin u_a = b2b_a[i]; u_b = b2b_b[i]; end
            tick;
            if (i >= 1) begin
                chk("b2b_valid", u_out_valid, 1);
                chk("b2b_q",     u_q,         b2b_exp[i-1]);
            end
        end
        u_in_valid = 1'b0;
        tick;

        // Signed back-to-back
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_valid = (i < 3);
            if (i < 3) begin s_a = sg_a[i]; s_b = sg_b[i]; end
            tick;
            if (i >= 1) begin
                chk("sgn_valid", s_out_valid, 1);
                chk("sgn_q",     s_q,         sg_exp[i-1]);
            end
        end
        s_in_valid = 1'b0;

        // Backpressure: out_ready low for cycles 2..4
        idx = 0; oidx = 0; held_v = 1'b0; held_q = '0;
        for (int cyc = 0; cyc < 30 && oidx < 4; cyc++) begin
            u_in_valid = (idx < 4);
            if (idx < 4) begin u_a = bp_a[idx]; u_b = bp_b[idx]; end
            u_out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (held_v) begin
                chk("bp_hold_valid", u_out_valid, 1);
                chk("bp_hold_q",     u_q,         held_q);
            end
            if (u_out_valid && !u_out_ready) chk("bp_in_ready", u_in_ready, 0);
            chk("bp_inflight_le2", (u_inflight <= 2), 1);
            in_x  = u_in_valid && u_in_ready;
            out_x = u_out_valid && u_out_ready;
            if (out_x) begin
                chk("bp_q", u_q, bp_exp[oidx]);
                oidx++;
            end
            held_v = u_out_valid && !u_out_ready;
            held_q = u_q;
            tick;
            if (in_x) idx++;
        end
        chk("bp_count", oidx, 4);
        u_in_valid = 1'b0;
        u_out_ready = 1'b1;
        tick;

        // Reset with 2 entries in flight
        u_out_ready = 1'b0;
        u_in_valid = 1'b1; u_a = 4'd5; u_b = 4'd5;
        tick;
        u_a = 4'd6; u_b = 4'd6;
        tick;
        u_in_valid = 1'b0;
        chk("mid_inflight", u_inflight, 2);
        chk("mid_valid",    u_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    u_out_valid, 0);
        chk("mid_rst_q",        u_q,         0);
        chk("mid_rst_inflight", u_inflight,  0);
        #2 rst_n = 1'b1;
        u_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_valid",    u_out_valid, 0);
            chk("post_rst_inflight", u_inflight,  0);
        end

        // Combinational instance
        c_a = 4'd7; c_b = 4'd9; c_in_valid = 1'b1; c_out_ready = 1'b1;
        #1;
        chk("comb_q",        c_q,         8'h3F);
        chk("comb_valid",    c_out_valid, 1);
        chk("comb_ready_hi", c_in_ready,  1);
        chk("comb_inflight", c_inflight,  0);
        c_out_ready = 1'b0;
        #1;
        chk("comb_ready_lo", c_in_ready, 0);
        c_in_valid = 1'b0;
        #1;
        chk("comb_valid_lo", c_out_valid, 0);
        tick;

        // 2+2: one entry, then stall output and keep offering inputs
        d_out_ready = 1'b0;
        d_in_valid = 1'b1; d_a = 4'd3; d_b = 4'd3;
        tick;
        d_in_valid = 1'b0;
        tick;
        tick;
        chk("bc_early_valid", d_out_valid, 0);
        tick;
        chk("bc_valid", d_out_valid, 1);
        chk("bc_q",     d_q,         8'h09);
        for (int j = 0; j < 4; j++) begin
            d_in_valid = 1'b1; d_a = 4'(j + 1); d_b = 4'd2;
            #1;
            chk("bc_in_ready", d_in_ready, bc_rdy[j]);
            chk("bc_inflight", d_inflight, bc_cnt[j]);
            tick;
        end
        d_in_valid = 1'b0;
        chk("bc_inflight_final", d_inflight, bc_cnt[3] + ((bc_rdy[3]) ? 3'd1 : 3'd0));
        d_out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (d_out_valid) begin
                if (n < 4) chk("bc_drain_q", d_q, bc_exp[n]);
                n++;
            end
            tick;
        end
        chk("bc_drain_count", n, bc_n);
        chk("bc_drain_inflight", d_inflight, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
